// File: rtl/universal_reg_pkg.sv
// Shared mode encoding for the universal register and its next-state generator.
package universal_reg_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_INC  = 3'b110;
    localparam mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/universal_reg_next.sv
// Combinational next-value and flag generator; strobes mark which state each mode updates.
module universal_reg_next
    import universal_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q_nxt,
    output logic             sout_nxt,
    output logic             carry_nxt,
    output logic             q_upd,
    output logic             sout_upd,
    output logic             carry_upd
);

    // One extra bit so the MSB of the result is the carry/borrow.
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    assign inc_w = {1'b0, q} + (WIDTH+1)'(1);
    assign dec_w = {1'b0, q} - (WIDTH+1)'(1);

    // Unknown modes fall through to default, which behaves as HOLD.
    always_comb begin
        q_nxt     = q;
        sout_nxt  = 1'b0;
        carry_nxt = 1'b0;
        q_upd     = 1'b0;
        sout_upd  = 1'b0;
        carry_upd = 1'b0;
        case (mode)
            MODE_LOAD: begin
                q_nxt = d;
                q_upd = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = {q[WIDTH-2:0], sin};
                sout_nxt = q[WIDTH-1];
                q_upd    = 1'b1;
                sout_upd = 1'b1;
            end
            MODE_SHR: begin
                q_nxt    = {sin, q[WIDTH-1:1]};
                sout_nxt = q[0];
                q_upd    = 1'b1;
                sout_upd = 1'b1;
            end
            MODE_ROL: begin
                q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_nxt = q[WIDTH-1];
                q_upd    = 1'b1;
                sout_upd = 1'b1;
            end
            MODE_ROR: begin
                q_nxt    = {q[0], q[WIDTH-1:1]};
                sout_nxt = q[0];
                q_upd    = 1'b1;
                sout_upd = 1'b1;
            end
            MODE_INC: begin
                q_nxt     = inc_w[WIDTH-1:0];
                carry_nxt = inc_w[WIDTH];
                q_upd     = 1'b1;
                carry_upd = 1'b1;
            end
            MODE_DEC: begin
                q_nxt     = dec_w[WIDTH-1:0];
                carry_nxt = dec_w[WIDTH];
                q_upd     = 1'b1;
                carry_upd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_reg.sv
// WIDTH-bit edge-triggered universal register: load, shift, rotate, inc/dec with serial out and carry.
module universal_reg
    import universal_reg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             carry
);

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             carry_nxt;
    logic             q_upd;
    logic             sout_upd;
    logic             carry_upd;

    universal_reg_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q        (q),
        .mode     (mode),
        .d        (d),
        .sin      (sin),
        .q_nxt    (q_nxt),
        .sout_nxt (sout_nxt),
        .carry_nxt(carry_nxt),
        .q_upd    (q_upd),
        .sout_upd (sout_upd),
        .carry_upd(carry_upd)
    );

    // rst beats en; en=0 holds everything; each flop updates only on its strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            sout  <= 1'b0;
            carry <= 1'b0;
        end else if (en) begin
            if (q_upd)     q     <= q_nxt;
            if (sout_upd)  sout  <= sout_nxt;
            if (carry_upd) carry <= carry_nxt;
        end
    end

endmodule

// File: tb/tb_universal_reg.sv
// Directed plus randomized checks of universal_reg against an arithmetic reference model.
module tb_universal_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       carry;
    logic [7:0] q2;
    logic       sout2;
    logic       carry2;

    int n_tests;
    int n_fail;

    int unsigned mq;
    bit          ms;
    bit          mc;

    universal_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q), .sout(sout), .carry(carry)
    );

    universal_reg #(.WIDTH(8), .RST_VAL(8'h3C)) dut_rv (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q2), .sout(sout2), .carry(carry2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: register value as a plain integer in 0..255.
    task automatic model(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic s);
        int unsigned s_i;
        s_i = s ? 1 : 0;
        if (r) begin
            mq = 0; ms = 0; mc = 0;
        end else if (e && !$isunknown(m)) begin
            case (m)
                3'd1: mq = dd;
                3'd2: begin ms = (mq >= 128); mq = (mq * 2 + s_i) % 256; end
                3'd3: begin ms = (mq % 2 == 1); mq = mq / 2 + s_i * 128; end
                3'd4: begin ms = (mq >= 128); mq = (mq * 2) % 256 + mq / 128; end
                3'd5: begin ms = (mq % 2 == 1); mq = mq / 2 + (mq % 2) * 128; end
                3'd6: begin mc = (mq == 255); mq = (mq + 1) % 256; end
                3'd7: begin mc = (mq == 0); mq = (mq + 255) % 256; end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic s);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dd; sin = s;
        model(r, e, m, dd, s);
        @(posedge clk);
        #1;
        chk("q", 64'(q), 64'(mq));
        chk("sout", 64'(sout), 64'(ms));
        chk("carry", 64'(carry), 64'(mc));
        if (r) chk("q_rstval", 64'(q2), 64'h3C);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mq = 0; ms = 0; mc = 0;
        clk = 1'b0; rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sin = 1'b0;

        // Reset overrides an enabled LOAD
        step(1'b1, 1'b1, 3'd1, 8'hA5, 1'b1);
        chk("reset_q", 64'(q), 64'h00);
        chk("reset_q_rstval", 64'(q2), 64'h3C);

        // Load then hold with en=0 while d toggles
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 3'd1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 3'd2, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 3'd6, 8'h00, 1'b0);
        chk("hold_q", 64'(q), 64'hA5);

        // Shifts
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        chk("shl_q", 64'(q), 64'h4B);
        chk("shl_sout", 64'(sout), 64'h1);
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
        chk("shr_q", 64'(q), 64'h25);
        chk("shr_sout", 64'(sout), 64'h1);

        // Rotates
        step(1'b0, 1'b1, 3'd1, 8'h81, 1'b0);
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
        chk("rol_q", 64'(q), 64'h03);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        chk("ror1_q", 64'(q), 64'h81);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        chk("ror2_q", 64'(q), 64'hC0);
        chk("ror2_sout", 64'(sout), 64'h1);

        // Increment/decrement across the wrap boundaries
        step(1'b0, 1'b1, 3'd1, 8'hFE, 1'b0);
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        chk("inc1_q", 64'(q), 64'hFF);
        chk("inc1_c", 64'(carry), 64'h0);
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        chk("inc2_q", 64'(q), 64'h00);
        chk("inc2_c", 64'(carry), 64'h1);
        step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0);
        chk("dec1_q", 64'(q), 64'hFF);
        chk("dec1_c", 64'(carry), 64'h1);
        step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0);
        chk("dec2_q", 64'(q), 64'hFE);
        chk("dec2_c", 64'(carry), 64'h0);

        // Unknown mode behaves as HOLD
        step(1'b0, 1'b1, 3'bxxx, 8'h12, 1'b1);
        chk("xmode_q", 64'(q), 64'hFE);

        // Reset in the middle of a shift train
        step(1'b0, 1'b1, 3'd1, 8'h0F, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        step(1'b1, 1'b1, 3'd2, 8'h00, 1'b1);
        chk("midrst_q", 64'(q), 64'h00);
        chk("midrst_sout", 64'(sout), 64'h0);
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        chk("postrst_inc_q", 64'(q), 64'h01);
        chk("postrst_inc_c", 64'(carry), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
